opf_chan_scheduler: RTL and testbench
=====================================

// Module: opf_chan_scheduler
// PURPOSE
//  Sits between the per-channel PID stages and output_filter. Holds one pending PID sum per channel,
//  coalesces sums arriving for a channel not yet issued, and issues at most one channel per cycle
//  to the filter in round-robin order. Enforces a per-channel lockout so a channel is never
//  re-issued while its previous value is still in the filter pipeline (stale prev-output hazard).
// PARAMETERS
//  N_CHAN      8   number of channels
//  W_CHAN      5   channel index width (>= clog2(N_CHAN))
//  W_DATA      18  signed PID sum width, in and out
//  PIPE_DEPTH  4   filter latency; min issue spacing for the same channel, in cycles
// PORTS
//  clk_in       in   1         system clock
//  sys_rst_in   in   1         reset, asynchronous, active-high
//  chan_rst_in  in   N_CHAN    per-channel synchronous clear
//  chan_en_in   in   N_CHAN    per-channel issue enable
//  dv_in        in   1         input sum valid
//  chan_in      in   W_CHAN    input channel
//  data_in      in   W_DATA    signed PID sum
//  dv_out       out  1         issue valid to output_filter
//  chan_out     out  W_CHAN    issued channel
//  data_out     out  W_DATA    issued signed sum
//  pend_out     out  N_CHAN    per-channel pending flags
//  ovf_out      out  1         1-cycle pulse: a coalescing add saturated
// BEHAVIOUR
//  - Reset (async, sys_rst_in=1): dv_out, chan_out, data_out, ovf_out, pend_out, all slots, lock
//    counters = 0; RR pointer = N_CHAN-1 (channel 0 wins first). No ready/backpressure downstream.
//  - Accept: dv_in=1 with chan_in<N_CHAN always accepted; chan_in>=N_CHAN ignored.
//    Slot c not pending -> slot=data_in, pend[c]=1. Slot c pending -> slot=sat(slot+data_in),
//    add in W_DATA+1 bits, clamp to [-2^(W_DATA-1), 2^(W_DATA-1)-1]; ovf_out=1 next cycle if clamped.
//  - Eligible(c) = pend[c] & chan_en_in[c] & ~chan_rst_in[c] & (lock[c]==0).
//  - Arbiter: each cycle search c = ptr+1 .. ptr+N_CHAN (mod N_CHAN); first eligible wins.
//    Winner: registered dv_out=1, chan_out=c, data_out=slot[c]; pend[c] cleared, ptr=c,
//    lock[c]=PIPE_DEPTH-1. No winner: dv_out=0, chan_out/data_out hold last value.
//  - Latency: sum captured at edge E is earliest on dv_out after edge E+1 (no bypass).
//  - lock[c] decrements by 1 per cycle to 0 -> issues of same channel spaced >= PIPE_DEPTH cycles.
//  - Same-cycle dv_in for c and issue of c: issue carries old slot; new data_in becomes fresh
//    pending value (no add, no ovf). Sum is never lost or double-counted.
//  - chan_rst_in[c]=1: pend[c]=0, slot=0, c not issued that cycle; overrides same-cycle dv_in for c.
//    lock[c] keeps counting (in-flight data). Other channels unaffected.
//  - chan_en_in[c]=0: c keeps accepting/coalescing; issued once re-enabled.
//  - pend_out = registered pend flags. ovf_out otherwise 0.
// TESTING
//  1 reset; dv_in chan2 data 100 -> one cycle later dv_out=1 chan_out=2 data_out=100; pend_out[2]=0.
//  2 en[1]=0; feed chan1 100 then -30; en[1]=1 -> exactly one issue chan1 data_out=70.
//  3 en[1]=0; feed 131071 then 5 -> ovf_out pulses once; on enable data_out=131071.
//  4 chans 0,3,5 pending with ptr=N_CHAN-1 -> issues 0,3,5 on three consecutive cycles.
//  5 chan4 fed data 1 every cycle for 20 cycles -> chan4 issues spaced >= 4 cycles; sum of
//    data_out for chan4 after drain = 20.
//  6 chan_rst_in[2] while chan2 pending -> no chan2 issue; sys_rst_in mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/opf_chan_scheduler_if.sv
// Purpose : bundles the PID-sum ingress bus, per-channel controls and the filter issue bus.
// Latency : n/a (wiring only).
// Backpressure: none; the scheduler always accepts and the filter always consumes.
// Ports (slave side = scheduler):
//   chan_rst_in/chan_en_in : per-channel sync clear / issue enable
//   dv_in/chan_in/data_in  : incoming PID sum
//   dv_out/chan_out/data_out, pend_out, ovf_out : issue bus and status
interface opf_chan_scheduler_if #(
  parameter int N_CHAN = 8,
  parameter int W_CHAN = 5,
  parameter int W_DATA = 18
);
  logic [N_CHAN-1:0]        chan_rst_in;
  logic [N_CHAN-1:0]        chan_en_in;
  logic                     dv_in;
  logic [W_CHAN-1:0]        chan_in;
  logic signed [W_DATA-1:0] data_in;

  logic                     dv_out;
  logic [W_CHAN-1:0]        chan_out;
  logic signed [W_DATA-1:0] data_out;
  logic [N_CHAN-1:0]        pend_out;
  logic                     ovf_out;

  // Upstream side (PID stages / control)
  modport master (
    output chan_rst_in, chan_en_in, dv_in, chan_in, data_in,
    input  dv_out, chan_out, data_out, pend_out, ovf_out
  );

  // Scheduler side
  modport slave (
    input  chan_rst_in, chan_en_in, dv_in, chan_in, data_in,
    output dv_out, chan_out, data_out, pend_out, ovf_out
  );
endinterface

// File: rtl/opf_chan_scheduler.sv
// Purpose : holds one pending PID sum per channel (coalescing with saturation) and issues at most
//           one channel per cycle to output_filter in round-robin order, with per-channel lockout.
// Latency : a sum captured at edge E appears on dv_out no earlier than after edge E+1.
// Backpressure: none; every in-range input is accepted, issues are never stalled downstream.
// Ports   : clk_in, sys_rst_in (async, active-high); bus = opf_chan_scheduler_if.slave
//           (ingress dv/chan/data, per-channel rst/en, issue dv/chan/data, pend flags, ovf pulse).
module opf_chan_scheduler #(
  parameter int N_CHAN     = 8,
  parameter int W_CHAN     = 5,
  parameter int W_DATA     = 18,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  sys_rst_in,
  opf_chan_scheduler_if.slave   bus
);

  localparam int W_LOCK = $clog2(PIPE_DEPTH + 1);
  localparam logic signed [W_DATA-1:0] SAT_MAX = {1'b0, {(W_DATA-1){1'b1}}};
  localparam logic signed [W_DATA-1:0] SAT_MIN = {1'b1, {(W_DATA-1){1'b0}}};

  // Per-channel state
  logic signed [W_DATA-1:0] slot_q [N_CHAN];
  logic [W_LOCK-1:0]        lock_q [N_CHAN];
  logic [N_CHAN-1:0]        pend_q;
  logic [W_CHAN-1:0]        ptr_q;

  // Registered outputs
  logic                     dv_q;
  logic [W_CHAN-1:0]        chan_q;
  logic signed [W_DATA-1:0] data_q;
  logic                     ovf_q;

  // Combinational decode
  logic [N_CHAN-1:0]        elig;
  logic [N_CHAN-1:0]        acc_oh;
  logic [N_CHAN-1:0]        clamp_v;
  logic [W_DATA:0]          sum_w  [N_CHAN];
  logic signed [W_DATA-1:0] sat_dat[N_CHAN];
  logic                     win_vld;
  logic [N_CHAN-1:0]        win_oh;
  logic [W_CHAN-1:0]        win_idx;
  logic signed [W_DATA-1:0] win_dat;
  logic                     ovf_d;

  // Eligibility, ingress decode and saturating coalesce add per channel.
  // Out-of-range chan_in never matches any c, so it is dropped implicitly.
  always_comb begin
    elig    = '0;
    acc_oh  = '0;
    clamp_v = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      elig[c]   = pend_q[c] & bus.chan_en_in[c] & ~bus.chan_rst_in[c] & (lock_q[c] == '0);
      acc_oh[c] = bus.dv_in & (bus.chan_in == W_CHAN'(c));
      // Sign-extend both operands by one bit so the true sum always fits.
      sum_w[c]  = {slot_q[c][W_DATA-1], slot_q[c]} + {bus.data_in[W_DATA-1], bus.data_in};
      // Top two bits disagree -> result left the W_DATA range.
      clamp_v[c] = sum_w[c][W_DATA] ^ sum_w[c][W_DATA-1];
      if (clamp_v[c]) begin
        sat_dat[c] = sum_w[c][W_DATA] ? SAT_MIN : SAT_MAX;
      end else begin
        sat_dat[c] = sum_w[c][W_DATA-1:0];
      end
    end
  end

  // Round-robin arbiter: scan channels above the pointer first, then wrap to 0..ptr.
  // The second pass includes ptr itself, so a lone eligible channel is still served.
  always_comb begin
    win_vld = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    win_dat = '0;
    for (int j = 0; j < N_CHAN; j++) begin
      if (!win_vld && elig[j] && (W_CHAN'(j) > ptr_q)) begin
        win_vld   = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = W_CHAN'(j);
        win_dat   = slot_q[j];
      end
    end
    for (int j = 0; j < N_CHAN; j++) begin
      if (!win_vld && elig[j] && (W_CHAN'(j) <= ptr_q)) begin
        win_vld   = 1'b1;
        win_oh[j] = 1'b1;
        win_idx   = W_CHAN'(j);
        win_dat   = slot_q[j];
      end
    end
  end

  // Overflow only counts for a genuine coalescing add: slot pending, not being issued
  // this cycle (that case starts a fresh value), and not being cleared.
  always_comb begin
    ovf_d = |(acc_oh & pend_q & ~win_oh & ~bus.chan_rst_in & clamp_v);
  end

  always_ff @(posedge clk_in or posedge sys_rst_in) begin
    if (sys_rst_in) begin
      pend_q <= '0;
      ptr_q  <= W_CHAN'(N_CHAN - 1);
      dv_q   <= 1'b0;
      chan_q <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      for (int c = 0; c < N_CHAN; c++) begin
        slot_q[c] <= '0;
        lock_q[c] <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      dv_q  <= win_vld;
      // With no winner the issue bus holds its last channel/data.
      if (win_vld) begin
        ptr_q  <= win_idx;
        chan_q <= win_idx;
        data_q <= win_dat;
      end

      for (int c = 0; c < N_CHAN; c++) begin
        if (bus.chan_rst_in[c]) begin
          // Clear wins over a same-cycle input for this channel.
          pend_q[c] <= 1'b0;
          slot_q[c] <= '0;
        end else if (acc_oh[c]) begin
          pend_q[c] <= 1'b1;
          // Issuing this cycle carries the old slot out; the new sum starts fresh.
          if (pend_q[c] && !win_oh[c]) begin
            slot_q[c] <= sat_dat[c];
          end else begin
            slot_q[c] <= bus.data_in;
          end
        end else if (win_oh[c]) begin
          pend_q[c] <= 1'b0;
        end

        // Lockout keeps running through a channel clear: the old value is still in flight.
        if (win_oh[c]) begin
          lock_q[c] <= W_LOCK'(PIPE_DEPTH - 1);
        end else if (lock_q[c] != '0) begin
          lock_q[c] <= lock_q[c] - W_LOCK'(1);
        end
      end
    end
  end

  assign bus.dv_out   = dv_q;
  assign bus.chan_out = chan_q;
  assign bus.data_out = data_q;
  assign bus.pend_out = pend_q;
  assign bus.ovf_out  = ovf_q;

endmodule

// File: tb/tb_opf_chan_scheduler.sv
// Purpose : self-checking bench for opf_chan_scheduler (scoreboard of expected issues).
// Latency : n/a.
// Backpressure: n/a.
module tb_opf_chan_scheduler;
  localparam int N_CHAN     = 8;
  localparam int W_CHAN     = 5;
  localparam int W_DATA     = 18;
  localparam int PIPE_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  opf_chan_scheduler_if #(.N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_DATA(W_DATA)) bus ();

  opf_chan_scheduler #(
    .N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_DATA(W_DATA), .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .clk_in     (clk),
    .sys_rst_in (rst),
    .bus        (bus)
  );

  typedef struct {
    int chan;
    int data;
    int cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   ovf_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: record every issue and overflow pulse seen on the output side.
  always @(negedge clk) begin
    rec_t r;
    if (!rst && bus.dv_out) begin
      r.chan = int'(bus.chan_out);
      r.data = int'(bus.data_out);
      r.cyc  = cyc;
      obs_q.push_back(r);
    end
    if (!rst && bus.ovf_out) ovf_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_obs(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic idle_inputs();
    bus.chan_rst_in = '0;
    bus.chan_en_in  = '1;
    bus.dv_in       = 1'b0;
    bus.chan_in     = '0;
    bus.data_in     = '0;
  endtask

  task automatic feed(input int ch, input int d);
    bus.dv_in   = 1'b1;
    bus.chan_in = W_CHAN'(ch);
    bus.data_in = W_DATA'(d);
    step();
    bus.dv_in   = 1'b0;
  endtask

  task automatic push_exp(input int ch, input int d);
    rec_t e;
    e.chan = ch;
    e.data = d;
    e.cyc  = 0;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
    obs_q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(2);
    checks++; if (bus.dv_out !== 1'b0) begin errors++; $display("FAIL reset_dv: got %0d expected 0", bus.dv_out); end
    checks++; if (bus.chan_out !== '0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", bus.chan_out); end
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data: got %0d expected 0", bus.data_out); end
    checks++; if (bus.pend_out !== '0) begin errors++; $display("FAIL reset_pend: got %h expected 00", bus.pend_out); end
    checks++; if (bus.ovf_out !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", bus.ovf_out); end
    rst = 1'b0;
    step();
    obs_q.delete();
  endtask

  task automatic test_single_issue();
    rec_t e, o;
    push_exp(2, 100);
    feed(2, 100);
    // Just after the capture edge: no bypass, slot pending.
    checks++; if (bus.dv_out !== 1'b0) begin errors++; $display("FAIL single_nobypass: dv_out %0d expected 0", bus.dv_out); end
    checks++; if (bus.pend_out !== 8'h04) begin errors++; $display("FAIL single_pend_set: got %h expected 04", bus.pend_out); end
    step();
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL single_pend_clr: got %h expected 00", bus.pend_out); end
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL single_issue: got %0d issues one cycle later, expected 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o.chan !== e.chan || o.data !== e.data) begin
        errors++; $display("FAIL single_issue: got chan %0d data %0d expected chan %0d data %0d", o.chan, o.data, e.chan, e.data);
      end
    end
    step(4);
    obs_q.delete();
  endtask

  task automatic test_coalesce();
    rec_t e, o;
    ovf_cnt = 0;
    bus.chan_en_in = 8'hFD;
    feed(1, 100);
    feed(1, -30);
    step(3);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL coal_disabled: got %0d issues expected 0", obs_q.size()); end
    checks++; if (bus.pend_out[1] !== 1'b1) begin errors++; $display("FAIL coal_pend: got %0d expected 1", bus.pend_out[1]); end
    push_exp(1, 70);
    bus.chan_en_in = 8'hFF;
    wait_obs(1, 10);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL coal_issue: no issue, expected chan %0d data %0d", e.chan, e.data);
    end else begin
      o = obs_q.pop_front();
      if (o.chan !== e.chan || o.data !== e.data) begin
        errors++; $display("FAIL coal_issue: got chan %0d data %0d expected chan %0d data %0d", o.chan, o.data, e.chan, e.data);
      end
    end
    step(6);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL coal_single: got %0d extra issues expected 0", obs_q.size()); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL coal_no_ovf: got %0d ovf pulses expected 0", ovf_cnt); end
    obs_q.delete();
  endtask

  task automatic test_saturate();
    rec_t e, o;
    ovf_cnt = 0;
    push_exp(1, 131071);
    push_exp(1, -131072);
    for (int pass = 0; pass < 2; pass++) begin
      bus.chan_en_in = 8'hFD;
      if (pass == 0) begin feed(1, 131071); feed(1, 5); end
      else           begin feed(1, -131072); feed(1, -1); end
      step(3);
      checks++; if (ovf_cnt != pass + 1) begin errors++; $display("FAIL sat_ovf_pulse%0d: got %0d pulses expected %0d", pass, ovf_cnt, pass + 1); end
      bus.chan_en_in = 8'hFF;
      wait_obs(1, 10);
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL sat_issue%0d: no issue, expected data %0d", pass, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.chan !== e.chan || o.data !== e.data) begin
          errors++; $display("FAIL sat_issue%0d: got chan %0d data %0d expected chan %0d data %0d", pass, o.chan, o.data, e.chan, e.data);
        end
      end
      step(6);
    end
    obs_q.delete();
  endtask

  task automatic test_round_robin();
    rec_t e, o;
    int prev_cyc;
    do_reset();
    bus.chan_en_in = 8'h00;
    feed(0, 10);
    feed(3, 30);
    feed(5, 50);
    push_exp(0, 10);
    push_exp(3, 30);
    push_exp(5, 50);
    bus.chan_en_in = 8'hFF;
    wait_obs(3, 10);
    prev_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rr_order%0d: no issue, expected chan %0d", i, e.chan);
      end else begin
        o = obs_q.pop_front();
        if (o.chan !== e.chan || o.data !== e.data) begin
          errors++; $display("FAIL rr_order%0d: got chan %0d data %0d expected chan %0d data %0d", i, o.chan, o.data, e.chan, e.data);
        end
        if (i > 0) begin
          checks++;
          if (o.cyc != prev_cyc + 1) begin errors++; $display("FAIL rr_consec%0d: got gap %0d expected 1", i, o.cyc - prev_cyc); end
        end
        prev_cyc = o.cyc;
      end
    end
    // Pointer now at 5: channel 6 beats channel 2, which wins after the wrap.
    bus.chan_en_in = 8'h00;
    feed(2, 20);
    feed(6, 60);
    push_exp(6, 60);
    push_exp(2, 20);
    bus.chan_en_in = 8'hFF;
    wait_obs(2, 10);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rr_wrap%0d: no issue, expected chan %0d", i, e.chan);
      end else begin
        o = obs_q.pop_front();
        if (o.chan !== e.chan || o.data !== e.data) begin
          errors++; $display("FAIL rr_wrap%0d: got chan %0d data %0d expected chan %0d data %0d", i, o.chan, o.data, e.chan, e.data);
        end
      end
    end
    step(4);
    obs_q.delete();
    // Out-of-range channel indices are dropped.
    feed(9, 77);
    feed(31, 88);
    step(4);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL oor_issue: got %0d issues expected 0", obs_q.size()); end
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL oor_pend: got %h expected 00", bus.pend_out); end
    obs_q.delete();
  endtask

  task automatic test_lockout();
    rec_t e;
    int sum, n, other, min_gap, last;
    ovf_cnt = 0;
    push_exp(4, 20);
    bus.dv_in   = 1'b1;
    bus.chan_in = W_CHAN'(4);
    bus.data_in = W_DATA'(1);
    step(20);
    bus.dv_in = 1'b0;
    step(12);
    sum = 0; n = 0; other = 0; min_gap = 1000; last = -1;
    while (obs_q.size() > 0) begin
      rec_t o;
      o = obs_q.pop_front();
      if (o.chan != 4) other++;
      else begin
        sum += o.data;
        if (last >= 0 && (o.cyc - last) < min_gap) min_gap = o.cyc - last;
        last = o.cyc;
        n++;
      end
    end
    e = exp_q.pop_front();
    checks++; if (sum != e.data) begin errors++; $display("FAIL lock_sum: got %0d expected %0d", sum, e.data); end
    checks++; if (n < 2) begin errors++; $display("FAIL lock_count: got %0d issues expected at least 2", n); end
    checks++; if (min_gap < PIPE_DEPTH) begin errors++; $display("FAIL lock_spacing: got min gap %0d expected >= %0d", min_gap, PIPE_DEPTH); end
    checks++; if (other != 0) begin errors++; $display("FAIL lock_other: got %0d foreign issues expected 0", other); end
    checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL lock_ovf: got %0d pulses expected 0", ovf_cnt); end
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL lock_drain: pend %h expected 00", bus.pend_out); end
  endtask

  task automatic test_chan_reset();
    rec_t e, o;
    bus.chan_en_in = 8'h00;
    feed(2, 55);
    feed(3, 33);
    // Clear channel 2 while a new sum for it arrives in the same cycle.
    bus.chan_rst_in = 8'h04;
    feed(2, 9);
    bus.chan_rst_in = 8'h00;
    checks++; if (bus.pend_out !== 8'h08) begin errors++; $display("FAIL crst_pend: got %h expected 08", bus.pend_out); end
    push_exp(3, 33);
    bus.chan_en_in = 8'hFF;
    wait_obs(1, 10);
    e = exp_q.pop_front();
    checks++;
    if (obs_q.size() == 0) begin
      errors++; $display("FAIL crst_other: no issue, expected chan %0d data %0d", e.chan, e.data);
    end else begin
      o = obs_q.pop_front();
      if (o.chan !== e.chan || o.data !== e.data) begin
        errors++; $display("FAIL crst_other: got chan %0d data %0d expected chan %0d data %0d", o.chan, o.data, e.chan, e.data);
      end
    end
    step(6);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL crst_no_issue: got %0d issues expected 0", obs_q.size()); end
    // Clear arriving in the very cycle channel 2 would otherwise issue.
    feed(2, 7);
    bus.chan_rst_in = 8'h04;
    step();
    bus.chan_rst_in = 8'h00;
    step(4);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL crst_block: got %0d issues expected 0", obs_q.size()); end
    checks++; if (bus.pend_out !== 8'h00) begin errors++; $display("FAIL crst_pend_clr: got %h expected 00", bus.pend_out); end

    // Async system reset in the middle of traffic.
    bus.dv_in   = 1'b1;
    bus.chan_in = W_CHAN'(1);
    bus.data_in = W_DATA'(5);
    step(3);
    checks++; if (bus.chan_out !== W_CHAN'(1)) begin errors++; $display("FAIL srst_pre: chan_out %0d expected 1", bus.chan_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.dv_out !== 1'b0) begin errors++; $display("FAIL srst_dv: got %0d expected 0", bus.dv_out); end
    checks++; if (bus.chan_out !== '0) begin errors++; $display("FAIL srst_chan: got %0d expected 0", bus.chan_out); end
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL srst_data: got %0d expected 0", bus.data_out); end
    checks++; if (bus.pend_out !== '0) begin errors++; $display("FAIL srst_pend: got %h expected 00", bus.pend_out); end
    bus.dv_in = 1'b0;
    step();
    rst = 1'b0;
    step();
    obs_q.delete();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_issue();
    test_coalesce();
    test_saturate();
    test_round_robin();
    test_lockout();
    test_chan_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d unmatched expectations expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
